// File: rtl/aho_pkg.sv
// rtl/aho_pkg.sv - shared types, limits and 7-seg decode for the AHO LED controller
package aho_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } led_state_t;

  function automatic logic [6:0] seg_decode(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decimal digit of the event tally with ripple carry out
module bcd_digit
  import aho_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output bcd_t digit,
  output logic carry
);

  assign carry = inc & (digit == BCD_MAX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/aho_led_ctrl.sv
// rtl/aho_led_ctrl.sv - AHO event tally, LED stretch FSM, optional 7-seg scan (AHO_7SEG_EN)
module aho_led_ctrl
  import aho_pkg::*;
#(
  parameter int STRETCH  = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AHO,
  input  logic        CLR,
  output logic        LED,
  output logic [15:0] BCD,
  output logic        OVF
`ifdef AHO_7SEG_EN
  ,
  output logic [6:0]  SEG,
  output logic [3:0]  AN
`endif
);

  localparam int CW = $clog2(STRETCH + 1);

  bcd_t       d [4];
  logic [3:0] inc;
  logic [3:0] carry;

  // Units digit counts raw events; each higher digit counts its neighbour's wraps.
  assign inc = {carry[2:0], AHO};

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_digit u_digit (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (inc[g]),
      .clr   (CLR),
      .digit (d[g]),
      .carry (carry[g])
    );
  end

  assign BCD = {d[3], d[2], d[1], d[0]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVF <= 1'b0;
    end else if (CLR) begin
      OVF <= 1'b0;
    end else if (carry[3]) begin
      OVF <= 1'b1;
    end
  end

  led_state_t    state;
  logic [CW-1:0] hold_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else if (AHO) begin
      state    <= HOLD;
      hold_cnt <= CW'(STRETCH - 1);
    end else if (state == HOLD) begin
      if (hold_cnt == '0) begin
        state <= IDLE;
      end else begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign LED = (state == HOLD);

`ifdef AHO_7SEG_EN
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] scan_cnt;
  bcd_t          sel;

  always_comb begin
    sel = d[0];
    case (AN)
      4'b0010: sel = d[1];
      4'b0100: sel = d[2];
      4'b1000: sel = d[3];
      default: sel = d[0];
    endcase
  end

  // SEG follows the registered AN, so it settles one cycle after each digit switch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scan_cnt <= '0;
      AN       <= 4'b0001;
      SEG      <= SEG_0;
    end else begin
      SEG <= seg_decode(sel);
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        AN       <= {AN[2:0], AN[3]};
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aho_led_ctrl.sv
// tb/tb_aho_led_ctrl.sv - directed self-checking bench for aho_led_ctrl
module tb_aho_led_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AHO;
  logic        CLR;
  logic        LED;
  logic [15:0] BCD;
  logic        OVF;
`ifdef AHO_7SEG_EN
  logic [6:0]  SEG;
  logic [3:0]  AN;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  aho_led_ctrl #(
    .STRETCH  (4),
    .SCAN_DIV (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .AHO (AHO),
    .CLR (CLR),
    .LED (LED),
    .BCD (BCD),
    .OVF (OVF)
`ifdef AHO_7SEG_EN
    ,
    .SEG (SEG),
    .AN  (AN)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle event: LED must stay high for exactly four cycles.
  task automatic pulse_check(input string tag);
    AHO = 1'b1;
    tick();
    chk({tag, "_led0"}, 32'(LED), 32'd1);
    AHO = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, "_ledhold"}, 32'(LED), 32'd1);
    end
    tick();
    chk({tag, "_ledoff"}, 32'(LED), 32'd0);
  endtask

`ifdef AHO_7SEG_EN
  function automatic logic [6:0] exp_seg(input logic [3:0] an);
    case (an)
      4'b0001: return 7'h66;
      4'b0010: return 7'h4F;
      4'b0100: return 7'h5B;
      4'b1000: return 7'h06;
      default: return 7'h00;
    endcase
  endfunction
`endif

  initial begin
    RST = 1'b0;
    AHO = 1'b0;
    CLR = 1'b0;
    #2;
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_bcd", 32'(BCD), 32'h0000);
    chk("rst_ovf", 32'(OVF), 32'd0);
`ifdef AHO_7SEG_EN
    chk("rst_an", 32'(AN), 32'b0001);
    chk("rst_seg", 32'(SEG), 32'h3F);
`endif
    tick();
    tick();
    RST = 1'b1;

    // T1: three isolated events
    repeat (4) tick();
    pulse_check("t1a");
    repeat (10) tick();
    pulse_check("t1b");
    repeat (15) tick();
    pulse_check("t1c");
    chk("t1_bcd", 32'(BCD), 32'h0003);
    chk("t1_ovf", 32'(OVF), 32'd0);

    // T2: retrigger two cycles after the first event
    repeat (3) tick();
    AHO = 1'b1; tick(); chk("t2_e10", 32'(LED), 32'd1);
    AHO = 1'b0; tick(); chk("t2_e11", 32'(LED), 32'd1);
    AHO = 1'b1; tick(); chk("t2_e12", 32'(LED), 32'd1);
    AHO = 1'b0;
    for (int k = 13; k <= 15; k++) begin
      tick();
      chk("t2_hold", 32'(LED), 32'd1);
    end
    tick();
    chk("t2_off", 32'(LED), 32'd0);
    chk("t2_bcd", 32'(BCD), 32'h0005);

    // T3: long run to wrap
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("t3_clr_bcd", 32'(BCD), 32'h0000);
    AHO = 1'b1;
    for (int i = 1; i <= 9999; i++) begin
      tick();
      if (i == 9)   chk("t3_9",   32'(BCD), 32'h0009);
      if (i == 10)  chk("t3_10",  32'(BCD), 32'h0010);
      if (i == 100) chk("t3_100", 32'(BCD), 32'h0100);
      if (i == 1000) chk("t3_1000", 32'(BCD), 32'h1000);
    end
    chk("t3_9999", 32'(BCD), 32'h9999);
    chk("t3_ovf0", 32'(OVF), 32'd0);
    tick();
    chk("t3_wrap", 32'(BCD), 32'h0000);
    chk("t3_ovf1", 32'(OVF), 32'd1);
    tick();
    chk("t3_after", 32'(BCD), 32'h0001);
    chk("t3_sticky", 32'(OVF), 32'd1);

    // T4: bring tally to 0042 then CLR against a same-cycle event
    repeat (41) tick();
    AHO = 1'b0;
    repeat (6) tick();
    chk("t4_pre_bcd", 32'(BCD), 32'h0042);
    chk("t4_pre_ovf", 32'(OVF), 32'd1);
    chk("t4_pre_led", 32'(LED), 32'd0);
    CLR = 1'b1; AHO = 1'b1;
    tick();
    CLR = 1'b0; AHO = 1'b0;
    chk("t4_bcd", 32'(BCD), 32'h0000);
    chk("t4_ovf", 32'(OVF), 32'd0);
    chk("t4_led", 32'(LED), 32'd1);

    // T5: asynchronous reset in the middle of a hold
    repeat (5) tick();
    AHO = 1'b1;
    repeat (17) tick();
    AHO = 1'b0;
    chk("t5_bcd17", 32'(BCD), 32'h0017);
    tick();
    chk("t5_hold", 32'(LED), 32'd1);
    #3;
    RST = 1'b0;
    #1;
    chk("t5_async_led", 32'(LED), 32'd0);
    chk("t5_async_bcd", 32'(BCD), 32'h0000);
    tick();
    RST = 1'b1;
    tick();
    chk("t5_idle", 32'(LED), 32'd0);
    pulse_check("t5p");
    chk("t5_bcd1", 32'(BCD), 32'h0001);

`ifdef AHO_7SEG_EN
    // T6: scan of 1234
    begin
      logic [3:0] a;
      logic [3:0] r;
      int         k;
      CLR = 1'b1; tick(); CLR = 1'b0;
      AHO = 1'b1;
      repeat (1234) tick();
      AHO = 1'b0;
      tick();
      chk("t6_bcd", 32'(BCD), 32'h1234);
      a = AN;
      k = 0;
      while (AN === a && k < 8) begin
        tick();
        k++;
      end
      chk("t6_sync", 32'(k < 8), 32'd1);
      for (int s = 0; s < 4; s++) begin
        r = {a[2:0], a[3]};
        chk("t6_an", 32'(AN), 32'(r));
        tick();
        chk("t6_seg", 32'(SEG), 32'(exp_seg(r)));
        tick();
        tick();
        chk("t6_an_hold", 32'(AN), 32'(r));
        tick();
        a = r;
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
